// File: rtl/y86_trace_buffer.sv
// Retire-strobe trace buffer: circular capture of PC plus register channels, frozen a
// programmable number of samples after a trigger, then streamed out over valid/ready.
module y86_trace_buffer #(
    parameter int DATA_W     = 32,
    parameter int NUM_CH     = 9,
    parameter int DEPTH      = 16,
    parameter int POST_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       arm,
    input  logic                       sample_valid,
    input  logic [NUM_CH*DATA_W-1:0]   sample_data,
    input  logic                       trig_mode,
    input  logic [DATA_W-1:0]          trig_pc,
    input  logic                       trig_in,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_last,
    output logic                       rd_done,
    output logic [1:0]                 state,
    output logic [$clog2(DEPTH+1)-1:0] fill_count,
    output logic                       triggered
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0] FULL      = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] POST_LAST = CNT_W'((POST_DEPTH == 0) ? 0 : POST_DEPTH - 1);
    localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_POST = 2'd2, S_READ = 2'd3} state_t;

    state_t                             state_q, state_d;
    logic [NUM_CH-1:0][DATA_W-1:0]      mem [DEPTH];
    logic [PTR_W-1:0]                   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]                   post_cnt, remaining;
    logic [CH_W-1:0]                    rd_ch;

    logic             hit, capture, accept, ch_last, final_beat, enter_read;
    logic [PTR_W-1:0] wr_ptr_inc;
    logic [CNT_W-1:0] fill_inc;

    // Samples are only recorded while capturing, and an arm in the same cycle always wins.
    assign hit        = sample_valid && (trig_mode ? trig_in : (sample_data[DATA_W-1:0] == trig_pc));
    assign capture    = !arm && sample_valid && ((state_q == S_ARMED) || (state_q == S_POST));
    assign wr_ptr_inc = wr_ptr + 1'b1;
    assign fill_inc   = (fill_count == FULL) ? FULL : fill_count + 1'b1;
    assign accept     = (state_q == S_READ) && rd_ready;
    assign ch_last    = (rd_ch == CH_LAST);
    assign final_beat = accept && ch_last && (remaining == CNT_W'(1));
    assign enter_read = (state_d == S_READ) && (state_q != S_READ);

    assign state    = state_q;
    assign rd_valid = (state_q == S_READ);
    assign rd_last  = rd_valid && ch_last;
    assign rd_data  = mem[rd_ptr][rd_ch];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // NOTE: state_d is assigned before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        if (arm) begin
            state_d = S_ARMED;
        end else begin
            case (state_q)
                S_ARMED: if (capture && hit)
                             state_d = (POST_DEPTH == 0) ? S_READ : S_POST;
                S_POST:  if (capture && (post_cnt == POST_LAST))
                             state_d = S_READ;
                S_READ:  if (final_beat)
                             state_d = S_IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    // NOTE: the sample array has no reset; its contents are only read after being written.
    always_ff @(posedge clk) begin
        if (capture) mem[wr_ptr] <= sample_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            fill_count <= '0;
            post_cnt   <= '0;
            rd_ptr     <= '0;
            rd_ch      <= '0;
            remaining  <= '0;
            rd_done    <= 1'b0;
            triggered  <= 1'b0;
        end else begin
            rd_done <= 1'b0;
            if (arm) begin
                wr_ptr     <= '0;
                fill_count <= '0;
                post_cnt   <= '0;
                rd_ptr     <= '0;
                rd_ch      <= '0;
                remaining  <= '0;
                triggered  <= 1'b0;
            end else begin
                if (capture) begin
                    wr_ptr     <= wr_ptr_inc;
                    fill_count <= fill_inc;
                    if (state_q == S_POST) post_cnt <= post_cnt + 1'b1;
                end
                if ((state_q == S_ARMED) && capture && hit) begin
                    triggered <= 1'b1;
                    post_cnt  <= '0;
                end
                // Oldest entry sits at the write pointer once the ring has wrapped.
                if (enter_read) begin
                    rd_ptr    <= (fill_inc == FULL) ? wr_ptr_inc : '0;
                    rd_ch     <= '0;
                    remaining <= fill_inc;
                end
                if (accept) begin
                    if (ch_last) begin
                        rd_ch     <= '0;
                        rd_ptr    <= rd_ptr + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == CNT_W'(1)) rd_done <= 1'b1;
                    end else begin
                        rd_ch <= rd_ch + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_y86_trace_buffer.sv
// Directed bench for y86_trace_buffer with DEPTH=8, POST_DEPTH=3; channel 0 carries PC=4*i,
// channel c>0 carries {c, i}.
module tb_y86_trace_buffer;

    localparam int DATA_W     = 32;
    localparam int NUM_CH     = 9;
    localparam int DEPTH      = 8;
    localparam int POST_DEPTH = 3;
    localparam int CNT_W      = $clog2(DEPTH+1);

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     arm;
    logic                     sample_valid;
    logic [NUM_CH*DATA_W-1:0] sample_data;
    logic                     trig_mode;
    logic [DATA_W-1:0]        trig_pc;
    logic                     trig_in;
    logic                     rd_valid;
    logic                     rd_ready;
    logic [DATA_W-1:0]        rd_data;
    logic                     rd_last;
    logic                     rd_done;
    logic [1:0]               state;
    logic [CNT_W-1:0]         fill_count;
    logic                     triggered;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] beats[$];
    logic              lasts[$];
    int                done_cnt;
    logic              drain_timeout;

    y86_trace_buffer #(
        .DATA_W(DATA_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH), .POST_DEPTH(POST_DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .arm(arm), .sample_valid(sample_valid),
        .sample_data(sample_data), .trig_mode(trig_mode), .trig_pc(trig_pc),
        .trig_in(trig_in), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .rd_last(rd_last), .rd_done(rd_done), .state(state), .fill_count(fill_count),
        .triggered(triggered)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] chan_val(input int i, input int c);
        if (c == 0) return DATA_W'(4 * i);
        return (DATA_W'(c) << 24) | DATA_W'(i);
    endfunction

    function automatic logic [NUM_CH*DATA_W-1:0] mk(input int i);
        logic [NUM_CH*DATA_W-1:0] v;
        for (int c = 0; c < NUM_CH; c++) v[c*DATA_W +: DATA_W] = chan_val(i, c);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic send_samples(input int first, input int count);
        for (int k = 0; k < count; k++) begin
            sample_valid = 1'b1;
            sample_data  = mk(first + k);
            step();
        end
        sample_valid = 1'b0;
    endtask

    // Accepts every beat until rd_done, recording data/last, then watches 3 more cycles.
    task automatic drain(input int budget);
        beats.delete();
        lasts.delete();
        done_cnt      = 0;
        drain_timeout = 1'b1;
        rd_ready      = 1'b1;
        for (int k = 0; k < budget && drain_timeout; k++) begin
            if (rd_valid) begin
                beats.push_back(rd_data);
                lasts.push_back(rd_last);
            end
            step();
            if (rd_done) begin
                done_cnt++;
                drain_timeout = 1'b0;
            end
        end
        rd_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (rd_done) done_cnt++;
        end
    endtask

    task automatic test_reset();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++; if (fill_count !== '0) begin errors++; $display("FAIL reset_fill: got %0d expected 0", fill_count); end
        checks++; if (triggered !== 1'b0) begin errors++; $display("FAIL reset_triggered: got %b expected 0", triggered); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
        checks++; if (rd_done !== 1'b0) begin errors++; $display("FAIL reset_rd_done: got %b expected 0", rd_done); end
        checks++; if (rd_last !== 1'b0) begin errors++; $display("FAIL reset_rd_last: got %b expected 0", rd_last); end
        // Samples in IDLE are ignored.
        send_samples(0, 3);
        checks++; if (fill_count !== '0) begin errors++; $display("FAIL idle_ignore_fill: got %0d expected 0", fill_count); end
    endtask

    task automatic test_pc_trigger();
        logic [DATA_W-1:0] exp_d;
        logic              exp_l;
        trig_mode = 1'b0;
        trig_pc   = 32'h28;
        arm_pulse();
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL pc_armed_state: got %0d expected 1", state); end
        send_samples(0, 13);
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL pc_post_state: got %0d expected 2", state); end
        checks++; if (triggered !== 1'b1) begin errors++; $display("FAIL pc_triggered: got %b expected 1", triggered); end
        send_samples(13, 1);
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL pc_read_state: got %0d expected 3", state); end
        send_samples(14, 6);
        checks++; if (fill_count !== 4'd8) begin errors++; $display("FAIL pc_fill: got %0d expected 8", fill_count); end
        checks++; if (rd_data !== 32'h18) begin errors++; $display("FAIL pc_first_data: got %0h expected 18", rd_data); end
        drain(200);
        checks++; if (drain_timeout !== 1'b0) begin errors++; $display("FAIL pc_drain_timeout: got %b expected 0", drain_timeout); end
        checks++; if (beats.size() != 72) begin errors++; $display("FAIL pc_beat_count: got %0d expected 72", beats.size()); end
        for (int b = 0; b < beats.size() && b < 72; b++) begin
            exp_d = chan_val(6 + b / 9, b % 9);
            exp_l = ((b % 9) == 8);
            checks++; if (beats[b] !== exp_d) begin errors++; $display("FAIL pc_beat_data[%0d]: got %0h expected %0h", b, beats[b], exp_d); end
            checks++; if (lasts[b] !== exp_l) begin errors++; $display("FAIL pc_beat_last[%0d]: got %b expected %b", b, lasts[b], exp_l); end
        end
        if (beats.size() >= 64) begin
            checks++; if (beats[63] !== 32'h34) begin errors++; $display("FAIL pc_last_entry_pc: got %0h expected 34", beats[63]); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL pc_done_count: got %0d expected 1", done_cnt); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL pc_idle_after: got %0d expected 0", state); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL pc_rd_valid_after: got %b expected 0", rd_valid); end
        checks++; if (fill_count !== 4'd8) begin errors++; $display("FAIL pc_fill_hold: got %0d expected 8", fill_count); end
        checks++; if (triggered !== 1'b1) begin errors++; $display("FAIL pc_trig_hold: got %b expected 1", triggered); end
    endtask

    task automatic test_first_sample_trigger();
        logic [DATA_W-1:0] exp_d;
        trig_mode = 1'b0;
        trig_pc   = 32'h0;
        arm_pulse();
        send_samples(0, 6);
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL first_state: got %0d expected 3", state); end
        checks++; if (fill_count !== 4'd4) begin errors++; $display("FAIL first_fill: got %0d expected 4", fill_count); end
        drain(100);
        checks++; if (beats.size() != 36) begin errors++; $display("FAIL first_beat_count: got %0d expected 36", beats.size()); end
        for (int b = 0; b < beats.size() && b < 36; b++) begin
            exp_d = chan_val(b / 9, b % 9);
            checks++; if (beats[b] !== exp_d) begin errors++; $display("FAIL first_beat_data[%0d]: got %0h expected %0h", b, beats[b], exp_d); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL first_done_count: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_ext_trigger();
        trig_mode = 1'b1;
        trig_pc   = 32'hFFFF_FFF0;
        arm_pulse();
        trig_in = 1'b1;
        for (int k = 0; k < 3; k++) step();
        checks++; if (triggered !== 1'b0) begin errors++; $display("FAIL ext_no_trig: got %b expected 0", triggered); end
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL ext_still_armed: got %0d expected 1", state); end
        send_samples(0, 1);
        trig_in = 1'b0;
        checks++; if (triggered !== 1'b1) begin errors++; $display("FAIL ext_trig: got %b expected 1", triggered); end
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL ext_post_state: got %0d expected 2", state); end
        send_samples(1, 3);
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL ext_read_state: got %0d expected 3", state); end
        checks++; if (fill_count !== 4'd4) begin errors++; $display("FAIL ext_fill: got %0d expected 4", fill_count); end
    endtask

    // Continues from the READ state left by test_ext_trigger (samples 0..3 held).
    task automatic test_backpressure();
        logic [DATA_W-1:0] exp_d;
        rd_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            exp_d = chan_val(0, b);
            checks++; if (rd_data !== exp_d) begin errors++; $display("FAIL bp_pre_data[%0d]: got %0h expected %0h", b, rd_data, exp_d); end
            step();
        end
        rd_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++; if (rd_data !== chan_val(0, 4)) begin errors++; $display("FAIL bp_hold_data[%0d]: got %0h expected %0h", k, rd_data, chan_val(0, 4)); end
            checks++; if (rd_last !== 1'b0 || rd_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_flags[%0d]: got last=%b valid=%b expected last=0 valid=1", k, rd_last, rd_valid); end
        end
        drain(100);
        checks++; if (beats.size() != 32) begin errors++; $display("FAIL bp_beat_count: got %0d expected 32", beats.size()); end
        for (int b = 0; b < beats.size() && b < 32; b++) begin
            exp_d = chan_val((b + 4) / 9, (b + 4) % 9);
            checks++; if (beats[b] !== exp_d) begin errors++; $display("FAIL bp_beat_data[%0d]: got %0h expected %0h", b + 4, beats[b], exp_d); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp_done_count: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_arm_abort();
        trig_mode = 1'b0;
        trig_pc   = 32'h0;
        arm_pulse();
        send_samples(0, 4);
        rd_ready = 1'b1;
        for (int b = 0; b < 10; b++) step();
        checks++; if (rd_data !== chan_val(1, 1)) begin errors++; $display("FAIL abort_beat10: got %0h expected %0h", rd_data, chan_val(1, 1)); end
        arm = 1'b1;
        step();
        arm      = 1'b0;
        rd_ready = 1'b0;
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL abort_state: got %0d expected 1", state); end
        checks++; if (fill_count !== '0) begin errors++; $display("FAIL abort_fill: got %0d expected 0", fill_count); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL abort_rd_valid: got %b expected 0", rd_valid); end
        checks++; if (rd_done !== 1'b0) begin errors++; $display("FAIL abort_rd_done: got %b expected 0", rd_done); end
        checks++; if (triggered !== 1'b0) begin errors++; $display("FAIL abort_triggered: got %b expected 0", triggered); end
        step();
        checks++; if (rd_done !== 1'b0) begin errors++; $display("FAIL abort_rd_done_late: got %b expected 0", rd_done); end
        // arm together with a sample: the sample is dropped.
        arm          = 1'b1;
        sample_valid = 1'b1;
        sample_data  = mk(7);
        step();
        arm          = 1'b0;
        sample_valid = 1'b0;
        checks++; if (fill_count !== '0) begin errors++; $display("FAIL arm_wins_fill: got %0d expected 0", fill_count); end
    endtask

    task automatic test_reset_mid_post();
        trig_mode = 1'b0;
        trig_pc   = 32'h0;
        arm_pulse();
        send_samples(0, 2);
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL rst_pre_state: got %0d expected 2", state); end
        #2 reset = 1'b1;
        #1;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL rst_async_state: got %0d expected 0", state); end
        checks++; if (fill_count !== '0) begin errors++; $display("FAIL rst_async_fill: got %0d expected 0", fill_count); end
        checks++; if (triggered !== 1'b0) begin errors++; $display("FAIL rst_async_trig: got %b expected 0", triggered); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rst_async_rd_valid: got %b expected 0", rd_valid); end
        @(negedge clk);
        reset = 1'b0;
        send_samples(0, 4);
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL rst_after_state: got %0d expected 0", state); end
        checks++; if (fill_count !== '0) begin errors++; $display("FAIL rst_after_fill: got %0d expected 0", fill_count); end
    endtask

    initial begin
        reset        = 1'b1;
        arm          = 1'b0;
        sample_valid = 1'b0;
        sample_data  = '0;
        trig_mode    = 1'b0;
        trig_pc      = '0;
        trig_in      = 1'b0;
        rd_ready     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        test_reset();
        test_pc_trigger();
        test_first_sample_trigger();
        test_ext_trigger();
        test_backpressure();
        test_arm_abort();
        test_reset_mid_post();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/y86_trace_buffer.md
Name: y86_trace_buffer

Overview:
Synthesizable, parametrised successor to the simulation-only register trace monitor. Captures a snapshot of PC plus register-file channels on every retire strobe into a circular buffer. Capture stops a programmable number of samples after a trigger (PC match or external). The frozen window is then streamed out one word per beat over a valid/ready port. Sits beside the CPU core, fed from the current PC and register-file outputs.

Parameters:
DATA_W, 32, width of each channel word
NUM_CH, 9, channels per sample; channel 0 is PC, channels 1..NUM_CH-1 are registers in index order
DEPTH, 16, samples held in the circular buffer (power of 2, >=2)
POST_DEPTH, 4, samples captured after the trigger sample (0..DEPTH-1)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
arm  in  1  pulse: clear buffer and start capture
sample_valid  in  1  one sample offered this cycle (instruction retire)
sample_data  in  NUM_CH*DATA_W  channel c at bits [c*DATA_W +: DATA_W]
trig_mode  in  1  0 = PC match, 1 = external trig_in
trig_pc  in  DATA_W  PC compare value
trig_in  in  1  external trigger qualifier
rd_valid  out  1  readout word available
rd_ready  in  1  consumer accepts word
rd_data  out  DATA_W  readout word
rd_last  out  1  last channel of current sample
rd_done  out  1  one-cycle pulse after the final beat is accepted
state  out  2  0 IDLE, 1 ARMED, 2 POST, 3 READ
fill_count  out  $clog2(DEPTH+1)  valid samples held
triggered  out  1  trigger seen since last arm

Behaviour:
- Reset (async): state IDLE; wr_ptr, fill_count, post counter, rd_ptr, rd_ch = 0; rd_valid, rd_last, rd_done, triggered = 0; buffer contents don't-care.
- A sample "hits" when sample_valid=1 and (trig_mode=0 ? sample_data channel 0 == trig_pc : trig_in=1).
- IDLE: samples ignored. On arm -> ARMED with wr_ptr=0, fill_count=0, triggered=0.
- ARMED: each sample_valid writes all channels at wr_ptr. wr_ptr increments mod DEPTH. fill_count increments, saturating at DEPTH (oldest overwritten).
  - On a hit, the hit sample is written and triggered=1.
  - If POST_DEPTH=0 -> READ next cycle; else -> POST with post counter=0.
- POST: each sample_valid is written as in ARMED and increments the post counter. The write making the count equal POST_DEPTH -> READ. Further hits are ignored.
- Entering READ: rd_ptr = oldest entry (fill_count==DEPTH ? wr_ptr : 0); rd_ch=0; entries remaining = fill_count.
- READ:
  - rd_valid=1; rd_data = channel rd_ch of entry rd_ptr (combinational from array).
  - rd_data is stable while rd_valid && !rd_ready.
  - rd_last=1 when rd_ch==NUM_CH-1.
  - Beat accepted on rd_valid && rd_ready: rd_ch++. At the last channel, rd_ch=0, rd_ptr++ mod DEPTH, remaining--.
  - Accepting the final beat of the final entry -> IDLE; rd_done=1 for one cycle; rd_valid=0 from that next cycle.
  - fill_count and triggered hold through READ and IDLE until next arm.
  - Samples are ignored in READ.
- arm in any non-IDLE state aborts: same cycle-later result as arm from IDLE (ARMED, counters cleared, rd_valid=0 next cycle, no rd_done).
- arm and sample_valid in the same cycle: the sample is not captured; arm wins.
- Total samples read = min(pre-trigger samples + 1 + POST_DEPTH, DEPTH).
- Beats per capture = fill_count*NUM_CH.

Test Plan:
- Reset mid-POST (DEPTH=8, POST_DEPTH=3) -> state=0, fill_count=0, triggered=0, rd_valid=0 immediately (async); subsequent samples ignored.
- Arm; 20 samples with pc=4*i, trig_mode=0, trig_pc=0x28 (i=10) -> READ after i=13; fill_count=8; 72 beats; first rd_data=0x18; last-entry PC=0x34; rd_last on every 9th beat; rd_done once.
- Arm; trigger on first sample pc=0x00, POST_DEPTH=3 -> fill_count=4, entry PCs 0x00,0x04,0x08,0x0C, 36 beats.
- trig_mode=1: trig_in high with sample_valid low for 3 cycles -> no trigger. Then trig_in and sample_valid high together -> triggered=1 that cycle +1.
- Backpressure: rd_ready low for 5 cycles at beat 4 -> rd_data/rd_last held constant; beat order and count unchanged afterward.
- arm pulsed during READ at beat 10 -> state=ARMED, fill_count=0, rd_valid=0 next cycle, no rd_done pulse.
